// File: rtl/bft_pkg.sv
// rtl/bft_pkg.sv - BFT packet field layout, update FSM states and packet builder
package bft_pkg;

    localparam int PACKET_W  = 49;
    localparam int PAYLOAD_W = 32;
    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int TAG_W     = 7;

    localparam int VALID_BIT   = 48;
    localparam int LEAF_MSB    = 47;
    localparam int LEAF_LSB    = 43;
    localparam int PORT_MSB    = 42;
    localparam int PORT_LSB    = 39;
    localparam int TAG_MSB     = 38;
    localparam int TAG_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic {
        UPD_IDLE,
        UPD_REQ
    } upd_state_e;

    // Assemble a valid packet from its fields
    function automatic logic [PACKET_W-1:0] build_pkt(
        input logic [LEAF_W-1:0]    leaf,
        input logic [PORT_W-1:0]    port,
        input logic [TAG_W-1:0]     tag,
        input logic [PAYLOAD_W-1:0] payload
    );
        build_pkt = {1'b1, leaf, port, tag, payload};
    endfunction

endpackage

// File: rtl/leaf_rx_port_if.sv
// rtl/leaf_rx_port_if.sv - user stream and credit-update link bundle
interface leaf_rx_port_if;
    import bft_pkg::*;

    logic [PAYLOAD_W-1:0] dout_data;
    logic                 dout_vld;
    logic                 dout_ack;
    logic [PACKET_W-1:0]  upd_pkt;
    logic                 upd_req;
    logic                 upd_grant;

    modport master (
        output dout_data, dout_vld, upd_pkt, upd_req,
        input  dout_ack, upd_grant
    );

    modport slave (
        input  dout_data, dout_vld, upd_pkt, upd_req,
        output dout_ack, upd_grant
    );

endinterface

// File: rtl/bft_rx_fifo.sv
// rtl/bft_rx_fifo.sv - synchronous FIFO with registered show-ahead head word
module bft_rx_fifo #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_vld,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  head_q, head_d;
    logic              vld_q, vld_d;
    logic              push, pop;

    // Occupancy tops out at exactly DEPTH, so the MSB alone flags full
    assign full  = count_q[ADDR_W];
    assign push  = wr_en && !full;
    assign pop   = rd_en && vld_q;

    assign rd_data = head_q;
    assign rd_vld  = vld_q;
    assign empty   = !vld_q;
    assign count   = count_q;

    // Pointer/occupancy bookkeeping and refill of the show-ahead head register
    always_comb begin
        wptr_d  = wptr_q + ADDR_W'(push);
        rptr_d  = rptr_q + ADDR_W'(pop);
        count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        head_d  = head_q;
        if (pop) begin
            if (count_q > 1) begin
                head_d = mem_q[rptr_q + 1'b1];
            end else if (push) begin
                head_d = wr_data;
            end
        end else if (!vld_q && push) begin
            head_d = wr_data;
        end
        vld_d = (count_d != '0);
    end

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Control and head-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/leaf_rx_port.sv
// rtl/leaf_rx_port.sv - BFT leaf receive port with credit return
module leaf_rx_port
    import bft_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int MY_PORT               = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [PACKET_BITS-1:0]   pkt_in,
    input  logic [NUM_LEAF_BITS-1:0] ret_leaf,
    input  logic [NUM_PORT_BITS-1:0] ret_port,
    leaf_rx_port_if.master           io,
    output logic                     overflow
);

    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CW-1:0] UPD_SIZE = CW'(FREESPACE_UPDATE_SIZE);

    logic                   accept;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty_unused;
    logic [CW-1:0]          fifo_count_unused;
    logic                   unused_pkt_fields;

    upd_state_e             state_q, state_d;
    logic [CW-1:0]          freed_cnt_q, freed_cnt_d;
    logic                   upd_req_q, upd_req_d;
    logic [PACKET_BITS-1:0] upd_pkt_q, upd_pkt_d;
    logic                   overflow_q, overflow_d;

    // Routing already selected this leaf; only the port is filtered here
    assign accept = pkt_in[VALID_BIT] &&
                    (pkt_in[PORT_MSB:PORT_LSB] == NUM_PORT_BITS'(MY_PORT));
    assign unused_pkt_fields = ^{pkt_in[LEAF_MSB:LEAF_LSB], pkt_in[TAG_MSB:TAG_LSB]};
    assign pop = io.dout_vld && io.dout_ack;

    bft_rx_fifo #(
        .WIDTH  (PAYLOAD_BITS),
        .ADDR_W (NUM_BRAM_ADDR_BITS)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (accept),
        .wr_data (pkt_in[PAYLOAD_MSB:PAYLOAD_LSB]),
        .rd_en   (io.dout_ack),
        .rd_data (io.dout_data),
        .rd_vld  (io.dout_vld),
        .full    (fifo_full),
        .empty   (fifo_empty_unused),
        .count   (fifo_count_unused)
    );

    assign io.upd_req = upd_req_q;
    assign io.upd_pkt = upd_pkt_q;
    assign overflow   = overflow_q;

    // Credit accounting, update-request FSM and sticky drop flag
    always_comb begin
        overflow_d  = overflow_q | (accept & fifo_full);
        state_d     = state_q;
        freed_cnt_d = freed_cnt_q + CW'(pop);
        upd_req_d   = upd_req_q;
        upd_pkt_d   = upd_pkt_q;
        case (state_q)
            UPD_IDLE: begin
                if (freed_cnt_q >= UPD_SIZE) begin
                    state_d   = UPD_REQ;
                    upd_req_d = 1'b1;
                    upd_pkt_d = build_pkt(ret_leaf, ret_port, NUM_ADDR_BITS'(MY_PORT),
                                          PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE));
                end
            end
            UPD_REQ: begin
                if (io.upd_grant) begin
                    state_d     = UPD_IDLE;
                    upd_req_d   = 1'b0;
                    upd_pkt_d   = '0;
                    freed_cnt_d = freed_cnt_q - UPD_SIZE + CW'(pop);
                end
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= UPD_IDLE;
            freed_cnt_q <= '0;
            upd_req_q   <= 1'b0;
            upd_pkt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            freed_cnt_q <= freed_cnt_d;
            upd_req_q   <= upd_req_d;
            upd_pkt_q   <= upd_pkt_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_leaf_rx_port.sv
// tb/tb_leaf_rx_port.sv - self-checking bench for leaf_rx_port
module tb_leaf_rx_port;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [48:0] pkt_in;
    logic [4:0]  ret_leaf;
    logic [3:0]  ret_port;
    logic        overflow;

    leaf_rx_port_if io ();

    leaf_rx_port dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .pkt_in   (pkt_in),
        .ret_leaf (ret_leaf),
        .ret_port (ret_port),
        .io       (io.master),
        .overflow (overflow)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks;
    int n_fail;

    // Reference model: FIFO contents, freed-word count, request and drop flags
    logic [31:0] mq[$];
    int          m_freed;
    bit          m_req;
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_freed = 0;
        m_req   = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        bit acc, pop, full;
        acc  = pkt_in[48] && (pkt_in[42:39] == 4'd1);
        pop  = (mq.size() > 0) && io.dout_ack;
        full = (mq.size() == 128);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            if (full) m_ovf = 1;
            else      mq.push_back(pkt_in[31:0]);
        end
        if (m_req) begin
            if (io.upd_grant) begin
                m_req   = 0;
                m_freed = m_freed - 64 + int'(pop);
            end else begin
                m_freed = m_freed + int'(pop);
            end
        end else begin
            if (m_freed >= 64) m_req = 1;
            m_freed = m_freed + int'(pop);
        end
    endtask

    task automatic check_outputs();
        logic [48:0] exp_pkt;
        exp_pkt = {1'b1, ret_leaf, ret_port, 7'd1, 32'd64};
        check_eq("dout_vld", 64'(io.dout_vld), 64'(mq.size() != 0));
        if (mq.size() != 0) check_eq("dout_data", 64'(io.dout_data), 64'(mq[0]));
        check_eq("upd_req", 64'(io.upd_req), 64'(m_req));
        if (m_req) check_eq("upd_pkt", 64'(io.upd_pkt), 64'(exp_pkt));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge ap_clk);
        if (ap_rst_n) model_step();
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [31:0] payload);
        pkt_in = {1'b1, 5'd3, 4'd1, 7'd0, payload};
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        model_reset();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        ap_rst_n     = 1'b0;
        pkt_in       = '0;
        ret_leaf     = 5'd5;
        ret_port     = 4'd3;
        io.dout_ack  = 1'b0;
        io.upd_grant = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("rst_vld", 64'(io.dout_vld), 64'd0);
        check_eq("rst_data", 64'(io.dout_data), 64'd0);
        check_eq("rst_req", 64'(io.upd_req), 64'd0);
        check_eq("rst_pkt", 64'(io.upd_pkt), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        ap_rst_n = 1'b1;

        // Single word, one-cycle latency
        io.dout_ack = 1'b1;
        send(32'hDEADBEEF);
        cycle();
        check_eq("single_vld", 64'(io.dout_vld), 64'd1);
        check_eq("single_data", 64'(io.dout_data), 64'hDEADBEEF);
        pkt_in = '0;
        cycle();
        check_eq("single_drained", 64'(io.dout_vld), 64'd0);

        // Port filter and invalid packet
        pkt_in = {1'b1, 5'd3, 4'd2, 7'd0, 32'h11111111};
        cycle();
        check_eq("filter_port", 64'(io.dout_vld), 64'd0);
        pkt_in = {1'b0, 5'd3, 4'd1, 7'd0, 32'h22222222};
        cycle();
        check_eq("filter_valid", 64'(io.dout_vld), 64'd0);
        pkt_in = '0;

        // Backpressure and ordering
        io.dout_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(32'(i));
            cycle();
        end
        pkt_in = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("hold_data", 64'(io.dout_data), 64'd0);
        end
        io.dout_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("order_data", 64'(io.dout_data), 64'(i));
            cycle();
        end
        check_eq("order_empty", 64'(io.dout_vld), 64'd0);

        // Credit return
        do_reset();
        io.dout_ack = 1'b0;
        for (int i = 0; i < 70; i++) begin
            send(32'(1000 + i));
            cycle();
        end
        pkt_in = '0;
        io.dout_ack = 1'b1;
        for (int i = 0; i < 64; i++) cycle();
        check_eq("credit_no_req_yet", 64'(io.upd_req), 64'd0);
        io.dout_ack = 1'b0;
        cycle();
        check_eq("credit_req", 64'(io.upd_req), 64'd1);
        check_eq("credit_pkt", 64'(io.upd_pkt), 64'({1'b1, 5'd5, 4'd3, 7'd1, 32'd64}));
        io.dout_ack = 1'b1;
        cycle();
        cycle();
        io.upd_grant = 1'b1;
        cycle();
        io.upd_grant = 1'b0;
        check_eq("credit_req_dropped", 64'(io.upd_req), 64'd0);
        check_eq("credit_freed", 64'(dut.freed_cnt_q), 64'd3);
        check_eq("credit_freed_model", 64'(dut.freed_cnt_q), 64'(m_freed));

        // Overflow: 129th word dropped, first 128 delivered in order
        do_reset();
        io.dout_ack = 1'b0;
        for (int i = 0; i < 129; i++) begin
            send(32'(i));
            cycle();
        end
        pkt_in = '0;
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        io.dout_ack  = 1'b1;
        io.upd_grant = 1'b1;
        for (int i = 0; i < 128; i++) begin
            check_eq("ovf_order", 64'(io.dout_data), 64'(i));
            cycle();
        end
        check_eq("ovf_empty", 64'(io.dout_vld), 64'd0);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);

        // Reset while requesting with buffered words
        io.upd_grant = 1'b0;
        begin
            int budget;
            budget = 0;
            while (!m_req && budget < 300) begin
                send(32'($urandom));
                cycle();
                budget++;
            end
            if (!m_req) check_eq("timeout_req", 64'd0, 64'd1);
            io.dout_ack = 1'b0;
            budget = 0;
            while (mq.size() < 50 && budget < 100) begin
                send(32'($urandom));
                cycle();
                budget++;
            end
            if (mq.size() < 50) check_eq("timeout_fill", 64'd0, 64'd1);
        end
        pkt_in = '0;
        check_eq("pre_rst_req", 64'(io.upd_req), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        check_eq("midrst_req", 64'(io.upd_req), 64'd0);
        check_eq("midrst_vld", 64'(io.dout_vld), 64'd0);
        check_eq("midrst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        model_reset();
        ap_rst_n = 1'b1;
        cycle();
        check_eq("postrst_empty", 64'(io.dout_vld), 64'd0);

        // Randomized traffic against the model
        for (int blk = 0; blk < 15; blk++) begin
            int ackp;
            ackp = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 200; c++) begin
                pkt_in = {1'($urandom_range(1)), 5'($urandom), 4'($urandom_range(3)),
                          7'($urandom), 32'($urandom)};
                io.dout_ack  = ($urandom_range(99) < ackp);
                io.upd_grant = ($urandom_range(2) == 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_rx_port.md
Name: leaf_rx_port

Overview:
- Receive-side endpoint of the BFT leaf credit protocol.
- Accepts 49-bit packets from the BFT that are addressed to this input port, and buffers their payloads in a local FIFO.
- Presents the buffered payloads to user logic as a valid/ack stream.
- Returns freespace-update packets to the sending leaf each time FREESPACE_UPDATE_SIZE words have been consumed. This closes the sender's credit loop.
- Sits between the leaf's BFT ingress demux and one HLS input stream of a page.

Parameters:
PACKET_BITS, 49, total packet width
PAYLOAD_BITS, 32, payload field width
NUM_LEAF_BITS, 5, leaf address field width
NUM_PORT_BITS, 4, port field width
NUM_ADDR_BITS, 7, tag field width
NUM_BRAM_ADDR_BITS, 7, FIFO address width; depth DEPTH = 2**NUM_BRAM_ADDR_BITS = 128
FREESPACE_UPDATE_SIZE, 64, words freed per credit packet; must be <= DEPTH
MY_PORT, 1, port number this instance accepts

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
pkt_in  in  PACKET_BITS  ingress packet
- field [48] valid, [47:43] dst leaf, [42:39] dst port, [38:32] tag, [31:0] payload
ret_leaf  in  NUM_LEAF_BITS  leaf to which credits are returned; quasi-static
ret_port  in  NUM_PORT_BITS  port to which credits are returned; quasi-static
dout_data  out  PAYLOAD_BITS  user stream data
dout_vld  out  1  user stream valid
dout_ack  in  1  user stream ready
upd_pkt  out  PACKET_BITS  freespace-update packet
upd_req  out  1  request for the outbound link
upd_grant  in  1  outbound link granted this cycle
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert by use): FIFO is emptied, freed_cnt=0, overflow=0. Outputs go to dout_vld=0, dout_data=0, upd_req=0, upd_pkt=0. Credits not yet returned are lost; the sender must be reset together with this block.
- Accept condition: pkt_in[48]=1 and pkt_in[42:39]==MY_PORT. The leaf field is not checked, because routing has already been done.
- Write: the accepted payload is written at wptr. There is no backpressure toward the BFT.
- Full and write in the same cycle: the full check uses the occupancy at the start of the cycle. If occupancy == DEPTH, the word is dropped and overflow is set until reset, even if a pop occurs in that cycle.
- Latency: a word accepted in cycle t is visible at dout_data/dout_vld in cycle t+1 when the FIFO was empty. dout_data is taken from a registered show-ahead output.
- Handshake: a pop occurs when dout_vld && dout_ack. While dout_vld=1 and dout_ack=0, dout_data is held stable. Back-to-back pops sustain 1 word/cycle.
- Ordering: payloads are delivered in arrival order. Pointers wrap modulo DEPTH. Occupancy is NUM_BRAM_ADDR_BITS+1 bits wide.
- Credit counter: freed_cnt (NUM_BRAM_ADDR_BITS+1 bits) increments by 1 on each pop.
- Update FSM states:
  - IDLE → REQ when freed_cnt >= FREESPACE_UPDATE_SIZE.
  - In REQ, upd_req=1 and upd_pkt is held stable:
    - [48]=1, [47:43]=ret_leaf, [42:39]=ret_port, [38:32]=MY_PORT zero-extended
    - [31:0]=FREESPACE_UPDATE_SIZE
  - REQ → IDLE on upd_grant. In that cycle freed_cnt <= freed_cnt - FREESPACE_UPDATE_SIZE + pop.
  - REQ with no grant: stay in REQ and keep counting pops.
  - After a grant, REQ can be re-entered on the next cycle if the threshold is still met.
- upd_grant while in IDLE is ignored.
- freed_cnt cannot exceed DEPTH, because no more words can be popped than were written.

Decomposition:
- Package bft_pkg holds:
  - localparams for field positions: VALID_BIT, LEAF_MSB/LSB, PORT_MSB/LSB, TAG_MSB/LSB, PAYLOAD_MSB/LSB
  - a function that builds a packet from (leaf, port, tag, payload)
- Sub-module bft_rx_fifo: synchronous FIFO with show-ahead output register, parameterised by width and NUM_BRAM_ADDR_BITS, with full/empty/count outputs.
- The top level holds the accept filter, the credit counter, the update FSM and the overflow flag.

Test Plan:
- Single word: pkt_in = {1, leaf 3, port MY_PORT=1, tag 0, 0xDEADBEEF} in cycle 0, dout_ack=1 → dout_vld=1 with 0xDEADBEEF in cycle 1; no upd_req.
- Port filter: packet with port 2, then packet with valid=0 → dout_vld stays 0; occupancy stays 0.
- Backpressure/order: write 0..9 with dout_ack=0, then assert dout_ack → data 0..9 in order on consecutive cycles, held while ack is low.
- Credit: ret_leaf=5, ret_port=3; write and pop 64 words → upd_req=1 with upd_pkt = {1,5,3,1,64}. Grant after 3 cycles while popping 1 word/cycle → freed_cnt=3 after the grant.
- Overflow: write 129 words with no pops → the 129th is dropped, overflow=1; the next 128 pops return words 0..127.
- Reset mid-operation: assert ap_rst_n=0 while in REQ holding 50 words → immediately upd_req=0, dout_vld=0, overflow=0; after release the FIFO is empty.
